// File: rtl/seq_detect_sched.sv
// seq_detect_sched: one run-end detector ("1110" / "0001") shared round-robin by
// NUM_CH serial channels, each keeping its own last-bit / run-length context.
// Build macro SEQ_DETECT_HIT_CNT_EN adds saturating per-channel hit counters;
// without it hit_cnt is tied to zero and no counter state exists.
module seq_detect_sched #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         bit_valid,
    input  logic [NUM_CH-1:0]         bit_data,
    output logic [NUM_CH-1:0]         bit_ready,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic [NUM_CH-1:0]         ch_clr,
    output logic                      det_valid,
    output logic [$clog2(NUM_CH)-1:0] det_ch,
    output logic                      det_type,
    output logic [NUM_CH*CNT_W-1:0]   hit_cnt
);

    localparam int unsigned CH_W    = $clog2(NUM_CH);
    localparam int unsigned IDX_W   = CH_W + 1;
    localparam logic [1:0]  RUN_MAX = 2'd3;

    logic [NUM_CH-1:0]      last_q, last_d;
    logic [NUM_CH-1:0][1:0] run_q, run_d;
    logic [CH_W-1:0]        ptr_q, ptr_d;
    logic                   det_valid_q, det_valid_d;
    logic [CH_W-1:0]        det_ch_q, det_ch_d;
    logic                   det_type_q, det_type_d;

    logic [NUM_CH-1:0]      req;
    logic [IDX_W-1:0]       arb_idx;
    logic                   gnt_any;
    logic [CH_W-1:0]        gnt_idx;
    logic                   gnt_bit;
    logic                   gnt_last;
    logic [1:0]             gnt_run;
    logic                   det_hit;

    // A clear pulse on a channel blocks its grant in the same cycle
    assign req = bit_valid & ch_en & ~ch_clr;

    // Round-robin grant search starting at ptr_q; nothing granted during reset
    always_comb begin
        bit_ready = '0;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        ptr_d     = ptr_q;
        arb_idx   = '0;
        if (!rst) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                arb_idx = IDX_W'(ptr_q) + IDX_W'(k);
                if (arb_idx >= IDX_W'(NUM_CH)) begin
                    arb_idx = arb_idx - IDX_W'(NUM_CH);
                end
                if (!gnt_any && req[arb_idx[CH_W-1:0]]) begin
                    gnt_any                       = 1'b1;
                    gnt_idx                       = arb_idx[CH_W-1:0];
                    bit_ready[arb_idx[CH_W-1:0]]  = 1'b1;
                    ptr_d = (arb_idx == IDX_W'(NUM_CH - 1)) ? '0
                                                            : CH_W'(arb_idx + IDX_W'(1));
                end
            end
        end
    end

    // Context update of the granted channel, detection decode, per-channel clear
    always_comb begin
        last_d      = last_q;
        run_d       = run_q;
        det_valid_d = 1'b0;
        det_ch_d    = det_ch_q;
        det_type_d  = det_type_q;
        gnt_bit     = bit_data[gnt_idx];
        gnt_last    = last_q[gnt_idx];
        gnt_run     = run_q[gnt_idx];
        det_hit     = gnt_any && (gnt_run == RUN_MAX) && (gnt_bit != gnt_last);
        if (gnt_any) begin
            if ((gnt_run == 2'd0) || (gnt_bit != gnt_last)) begin
                last_d[gnt_idx] = gnt_bit;
                run_d[gnt_idx]  = 2'd1;
            end else if (gnt_run != RUN_MAX) begin
                run_d[gnt_idx] = gnt_run + 2'd1;
            end
        end
        if (det_hit) begin
            det_valid_d = 1'b1;
            det_ch_d    = gnt_idx;
            det_type_d  = gnt_last;
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_clr[i]) begin
                last_d[i] = 1'b0;
                run_d[i]  = 2'd0;
            end
        end
    end

    // Context, pointer and detection output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= '0;
            run_q       <= '0;
            ptr_q       <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
            det_type_q  <= 1'b0;
        end else begin
            last_q      <= last_d;
            run_q       <= run_d;
            ptr_q       <= ptr_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
            det_type_q  <= det_type_d;
        end
    end

    assign det_valid = det_valid_q;
    assign det_ch    = det_ch_q;
    assign det_type  = det_type_q;

`ifdef SEQ_DETECT_HIT_CNT_EN
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Saturating per-channel hit counters, bumped alongside the detection strobe
    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_clr[i]) begin
                cnt_d[i] = '0;
            end else if (det_hit && (gnt_idx == CH_W'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_cnt = cnt_q;
`else
    assign hit_cnt = '0;
`endif

endmodule
